nth_root_param: RTL

NTH_ROOT_PARAM -- requirements
Module: nth_root_param

---
 rtl/nth_root_pkg.sv | 16 +
 rtl/nth_root_fxmul.sv | 21 ++
 rtl/nth_root_param.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/nth_root_pkg.sv
// Shared types and default geometry for the fixed-point nth-root block.
package nth_root_pkg;

  localparam int DEF_IN_W   = 10;
  localparam int DEF_FRAC_W = 10;
  localparam int DEF_EXP_W  = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIAL,
    S_POW,
    S_DECIDE,
    S_OUT
  } state_t;

endpackage

// File: rtl/nth_root_fxmul.sv
// Unsigned fixed-point multiply: full product, >>FRAC_W truncation and a flag
// for any product bit at or above OUT_W+FRAC_W.
module nth_root_fxmul #(
  parameter int OUT_W  = 20,
  parameter int FRAC_W = 10
) (
  input  logic [OUT_W-1:0] i_a,
  input  logic [OUT_W-1:0] i_b,
  output logic [OUT_W-1:0] o_p,
  output logic             o_ovf
);

  logic [2*OUT_W-1:0] w_full;

  always_comb begin
    w_full = i_a * i_b;
    o_p    = w_full[FRAC_W +: OUT_W];
    o_ovf  = |w_full[2*OUT_W-1:OUT_W+FRAC_W];
  end

endmodule

// File: rtl/nth_root_param.sv
// Bit-serial restoring nth root of an unsigned integer, result in
// Q(IN_W).(FRAC_W); one truncated multiply per cycle for the trial power.
module nth_root_param
  import nth_root_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int EXP_W  = DEF_EXP_W,
  parameter int OUT_W  = IN_W + FRAC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
);

  localparam logic [OUT_W-1:0] BIT_MSB = {1'b1, {(OUT_W-1){1'b0}}};

  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [OUT_W-1:0]   r_out_data;
  logic               r_out_err;
  logic [EXP_W-1:0]   r_exp;
  logic [OUT_W-1:0]   r_target;
  logic [OUT_W-1:0]   r_result;
  logic [OUT_W-1:0]   r_cand;
  logic [OUT_W-1:0]   r_pow;
  logic [EXP_W-1:0]   r_k;
  logic               r_ovf;
  logic [OUT_W-1:0]   r_bit;

  logic [OUT_W-1:0]   w_prod;
  logic               w_prod_ovf;
  logic [EXP_W-1:0]   w_k_inc;
  logic [OUT_W-1:0]   w_in_target;
  logic               w_fits;
  logic               w_exact;
  logic [OUT_W-1:0]   w_next_result;

  nth_root_fxmul #(
    .OUT_W  (OUT_W),
    .FRAC_W (FRAC_W)
  ) u_fxmul (
    .i_a   (r_pow),
    .i_b   (r_cand),
    .o_p   (w_prod),
    .o_ovf (w_prod_ovf)
  );

  always_comb begin
    w_k_inc       = r_k + EXP_W'(1);
    w_in_target   = {in_data, {FRAC_W{1'b0}}};
    w_fits        = !r_ovf && (r_pow <= r_target);
    w_exact       = !r_ovf && (r_pow == r_target);
    w_next_result = w_fits ? r_cand : r_result;
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
      r_exp       <= '0;
      r_target    <= '0;
      r_result    <= '0;
      r_cand      <= '0;
      r_pow       <= '0;
      r_k         <= '0;
      r_ovf       <= 1'b0;
      r_bit       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_exp      <= in_exp;
            r_target   <= w_in_target;
            r_in_ready <= 1'b0;
            if (in_exp == '0) begin
              r_state     <= S_OUT;
              r_out_valid <= 1'b1;
              r_out_data  <= '0;
              r_out_err   <= 1'b1;
            end else if (in_exp == EXP_W'(1) || in_data == '0) begin
              // Zero radicand bypasses the search: truncated powers of tiny
              // candidates would otherwise round to zero and be accepted.
              r_state     <= S_OUT;
              r_out_valid <= 1'b1;
              r_out_data  <= w_in_target;
              r_out_err   <= 1'b0;
            end else begin
              r_state  <= S_TRIAL;
              r_result <= '0;
              r_bit    <= BIT_MSB;
            end
          end
        end
        S_TRIAL: begin
          r_cand  <= r_result | r_bit;
          r_pow   <= r_result | r_bit;
          r_k     <= EXP_W'(1);
          r_ovf   <= 1'b0;
          r_state <= S_POW;
        end
        S_POW: begin
          r_pow <= w_prod;
          r_ovf <= r_ovf | w_prod_ovf;
          r_k   <= w_k_inc;
          if (w_k_inc == r_exp) r_state <= S_DECIDE;
        end
        S_DECIDE: begin
          r_result <= w_next_result;
          if (w_exact || r_bit[0]) begin
            r_state     <= S_OUT;
            r_out_valid <= 1'b1;
            r_out_data  <= w_next_result;
            r_out_err   <= 1'b0;
          end else begin
            r_bit   <= r_bit >> 1;
            r_state <= S_TRIAL;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
